hazard_scoreboard: RTL and testbench

Parametrised hazard-detection unit for the LEGv8 pipeline; it replaces the two-stage combinational RAW check with an internal scoreboard. It tracks its own shadow copy of in-flight destinations for a configurable number of post-decode stages. It supports a no-forwarding mode (stall until write-back) and a forwarding mode (load-use stall only), squashes on taken branches, and keeps a saturating stall-cycle counter. It sits beside the decode stage and drives the PC, IF/ID and ID/EX control.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/sb_match.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
//
// Shared definitions for the LEGv8 hazard scoreboard:
//   REG_W      - default register-index width
//   ZERO_REG   - default index of XZR, which never creates a hazard
//   sb_entry_t - one scoreboard entry describing an in-flight instruction
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_W    = 5;
  localparam int ZERO_REG = 31;

  // One in-flight instruction as seen by the hazard logic. The rd field width
  // follows the package REG_W, so the design's REG_W must match it.
  typedef struct packed {
    logic             valid;     // slot holds a real instruction
    logic [REG_W-1:0] rd;        // destination register index
    logic             regwrite;  // instruction writes rd
    logic             memread;   // instruction is a load
  } sb_entry_t;

endpackage : hazard_pkg

// File: rtl/sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
//
// Combinational compare of one scoreboard entry against the two source
// operands of the instruction in ID.
//
// Ports:
//   entry     in   scoreboard entry under test
//   rs1, rs2  in   source indices of the instruction in ID
//   rs1_used  in   rs1 is actually read
//   rs2_used  in   rs2 is actually read
//   hit       out  entry produces a register that ID reads
//   load_hit  out  hit, and the producing instruction is a load
// -----------------------------------------------------------------------------
module sb_match
  import hazard_pkg::sb_entry_t;
#(
  parameter int REG_W    = hazard_pkg::REG_W,
  parameter int ZERO_REG = hazard_pkg::ZERO_REG
) (
  input  sb_entry_t        entry,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  output logic             hit,
  output logic             load_hit
);

  logic producer;
  logic hit_rs1;
  logic hit_rs2;

  // A writer of XZR is never a producer: the register always reads as zero.
  assign producer = entry.valid && entry.regwrite &&
                    (entry.rd != REG_W'(ZERO_REG));

  assign hit_rs1  = producer && rs1_used && (entry.rd == rs1);
  assign hit_rs2  = producer && rs2_used && (entry.rd == rs2);

  assign hit      = hit_rs1 || hit_rs2;
  assign load_hit = hit && entry.memread;

endmodule : sb_match

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard-detection unit for the LEGv8 pipeline. Keeps a shadow copy of the
// destinations in flight in the DEPTH stages after decode (entry 0 = EX,
// entry DEPTH-1 = WB) and stalls the instruction in ID on a RAW dependency.
// With FWD_EN = 0 it stalls until the producer reaches write-back; with
// FWD_EN = 1 only the load-use case stalls. A taken branch flushes IF/ID and
// ID/EX and overrides any stall. A saturating counter records stall cycles.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   id_valid      in   IF/ID holds a real instruction
//   id_rs1/rs2    in   source indices of the instruction in ID
//   id_rs*_used   in   the corresponding source is actually read
//   id_rd         in   destination of the instruction in ID
//   id_regwrite   in   instruction in ID writes id_rd
//   id_memread    in   instruction in ID is a load
//   branch_taken  in   taken branch resolved in MEM this cycle
//   pc_enable     out  PC may advance
//   if_id_enable  out  IF/ID may load
//   if_id_flush   out  IF/ID loads a bubble
//   id_ex_bubble  out  ID/EX loads a bubble instead of decoded controls
//   stall         out  hazard stall active this cycle
//   stall_count   out  saturating count of stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import hazard_pkg::sb_entry_t;
#(
  parameter int REG_W    = hazard_pkg::REG_W,
  parameter int ZERO_REG = hazard_pkg::ZERO_REG,
  parameter int DEPTH    = 3,   // legal range 2..8
  parameter int FWD_EN   = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             branch_taken,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  sb_entry_t        sb [DEPTH];
  sb_entry_t        new_entry;
  logic [DEPTH-1:0] stall_hit;
  logic             hazard;

  // ---------------------------------------------------------------------------
  // Per-entry compare. Which entries may cause a stall depends on the mode:
  // without forwarding every entry before WB does (WB writes the register
  // file before ID reads it); with forwarding only a load sitting in EX does.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic hit;
    logic load_hit;

    sb_match #(
      .REG_W    (REG_W),
      .ZERO_REG (ZERO_REG)
    ) u_match (
      .entry    (sb[i]),
      .rs1      (id_rs1),
      .rs2      (id_rs2),
      .rs1_used (id_rs1_used),
      .rs2_used (id_rs2_used),
      .hit      (hit),
      .load_hit (load_hit)
    );

    assign stall_hit[i] = (FWD_EN != 0) ? ((i == 0) && load_hit)
                                        : ((i < DEPTH - 1) && hit);
  end

  assign hazard = |stall_hit;

  // ---------------------------------------------------------------------------
  // Pipeline control. The flush wins over the stall: the stalled instruction
  // is on the wrong path and is discarded, so the front end must move on.
  // ---------------------------------------------------------------------------
  assign stall        = id_valid && hazard && !branch_taken;
  assign pc_enable    = !stall;
  assign if_id_enable = !stall;
  assign if_id_flush  = branch_taken;
  assign id_ex_bubble = stall || branch_taken;

  // Entry 0 receives the ID instruction only when it really advances into
  // EX; a stall or a flush sends a bubble instead.
  // NOTE: always_comb assigns a full default first so no path leaves
  // new_entry unassigned, which would otherwise infer a latch.
  always_comb begin
    new_entry = '0;
    if (id_valid && !stall && !branch_taken) begin
      new_entry.valid    = 1'b1;
      new_entry.rd       = id_rd;
      new_entry.regwrite = id_regwrite;
      new_entry.memread  = id_memread;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard shift and stall counter. The array advances every cycle,
  // mirroring the real pipeline; the oldest entry simply falls off.
  // NOTE: the scoreboard is a handful of flops, not a RAM, and is cleared on
  // reset because stale valid bits would produce phantom stalls. Sequential
  // state uses non-blocking assignments so every entry shifts from the
  // pre-edge values.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb[i] <= '0;
      end
      stall_count <= '0;
    end else begin
      sb[0] <= new_entry;
      for (int i = 1; i < DEPTH; i++) begin
        sb[i] <= sb[i-1];
      end
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end
  end

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Three scoreboard configurations share one stimulus stream:
//   0: DEPTH 3, no forwarding, 16-bit counter
//   1: DEPTH 3, forwarding,    16-bit counter
//   2: DEPTH 4, no forwarding, 2-bit counter
// The reference model tracks, per register, the first cycle at which a
// dependent instruction in ID may proceed; expected outputs are queued by the
// driver and popped by an independent monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int NDUT = 3;
  localparam int XZR  = 31;

  typedef struct packed {
    logic        stall;
    logic        pc_en;
    logic        ifid_en;
    logic        flush;
    logic        bubble;
    logic [15:0] cnt;
  } exp_one_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       branch_taken;

  logic [NDUT-1:0] pc_en;
  logic [NDUT-1:0] ifid_en;
  logic [NDUT-1:0] flush;
  logic [NDUT-1:0] bubble;
  logic [NDUT-1:0] stl;
  logic [15:0]     cnt_a;
  logic [15:0]     cnt_b;
  logic [1:0]      cnt_c;

  hazard_scoreboard #(.DEPTH(3), .FWD_EN(0), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken(branch_taken),
    .pc_enable(pc_en[0]), .if_id_enable(ifid_en[0]), .if_id_flush(flush[0]),
    .id_ex_bubble(bubble[0]), .stall(stl[0]), .stall_count(cnt_a)
  );

  hazard_scoreboard #(.DEPTH(3), .FWD_EN(1), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken(branch_taken),
    .pc_enable(pc_en[1]), .if_id_enable(ifid_en[1]), .if_id_flush(flush[1]),
    .id_ex_bubble(bubble[1]), .stall(stl[1]), .stall_count(cnt_b)
  );

  hazard_scoreboard #(.DEPTH(4), .FWD_EN(0), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .branch_taken(branch_taken),
    .pc_enable(pc_en[2]), .if_id_enable(ifid_en[2]), .if_id_flush(flush[2]),
    .id_ex_bubble(bubble[2]), .stall(stl[2]), .stall_count(cnt_c)
  );

  // ---------------------------------------------------------------------------
  // Reference model: ready[d][r] is the first cycle in which a reader of r may
  // leave ID. A producer leaving ID in cycle c is readable from cycle
  // c+DEPTH without forwarding, c+2 for a forwarded load, c+1 otherwise.
  // ---------------------------------------------------------------------------
  int depth_m [NDUT] = '{3, 3, 4};
  int fwd_m   [NDUT] = '{0, 1, 0};
  int cmax_m  [NDUT] = '{65535, 65535, 3};
  int ready   [NDUT][32];
  int cnt_m   [NDUT];
  int cyc;

  exp_one_t exp_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic model_stall(int d);
    logic h;
    h = 1'b0;
    if (id_rs1_used && (int'(id_rs1) != XZR) && (cyc < ready[d][id_rs1])) h = 1'b1;
    if (id_rs2_used && (int'(id_rs2) != XZR) && (cyc < ready[d][id_rs2])) h = 1'b1;
    return id_valid && !branch_taken && h;
  endfunction

  function automatic exp_one_t get_act(int d);
    exp_one_t a;
    a.stall   = stl[d];
    a.pc_en   = pc_en[d];
    a.ifid_en = ifid_en[d];
    a.flush   = flush[d];
    a.bubble  = bubble[d];
    case (d)
      0:       a.cnt = cnt_a;
      1:       a.cnt = cnt_b;
      default: a.cnt = {14'd0, cnt_c};
    endcase
    return a;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      for (int r = 0; r < 32; r++) ready[d][r] = 0;
      cnt_m[d] = 0;
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance the model.
  task automatic cycle(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic br,
                       input logic rst);
    logic     s [NDUT];
    exp_one_t e;
    int       lat;
    reset = rst; id_valid = v; id_rs1 = r1; id_rs1_used = u1;
    id_rs2 = r2; id_rs2_used = u2; id_rd = rd; id_regwrite = rw;
    id_memread = mr; branch_taken = br;
    for (int d = 0; d < NDUT; d++) begin
      s[d]      = model_stall(d);
      e.stall   = s[d];
      e.pc_en   = !s[d];
      e.ifid_en = !s[d];
      e.flush   = br;
      e.bubble  = s[d] || br;
      e.cnt     = 16'(cnt_m[d]);
      exp_q.push_back(e);
    end
    if (rst) begin
      model_reset();
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        if (s[d] && (cnt_m[d] < cmax_m[d])) cnt_m[d]++;
        if (v && !s[d] && !br && rw && (int'(rd) != XZR)) begin
          lat = (fwd_m[d] != 0) ? (mr ? 1 : 0) : depth_m[d] - 1;
          if (cyc + 1 + lat > ready[d][rd]) ready[d][rd] = cyc + 1 + lat;
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Instruction shorthands: ALU op rd <- rs1, rs2; load rd <- [rs1].
  task automatic alu(input logic [4:0] rd, input logic [4:0] r1,
                     input logic [4:0] r2, input logic br);
    cycle(1, r1, 1, r2, 1, rd, 1, 0, br, 0);
  endtask

  task automatic ldur(input logic [4:0] rd, input logic [4:0] base);
    cycle(1, base, 1, 0, 0, rd, 1, 1, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares every configuration each cycle, away from the edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (exp_q.size() >= NDUT) begin
      for (int d = 0; d < NDUT; d++) begin
        exp_one_t e;
        exp_one_t a;
        e = exp_q.pop_front();
        a = get_act(d);
        check($sformatf("dut%0d_cyc%0d {stall,pc,ifid,flush,bub,cnt}", d, cyc),
              {11'd0, a}, {11'd0, e});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int wait_cnt;
    cyc = 0;
    model_reset();
    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset, then idle.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // ADD X1 then SUB X2,X1,X3 held in ID until it leaves.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    alu(1, 2, 3, 0);
    repeat (3) alu(2, 1, 3, 0);
    check("add_sub_stall_count_nofwd", 32'(cnt_a), 32'd2);
    idle(4);

    // Load-use and ALU-use with forwarding (and the same in the other modes).
    ldur(5, 10);
    repeat (2) alu(6, 5, 5, 0);
    idle(4);
    alu(7, 11, 12, 0);
    repeat (3) alu(8, 7, 7, 0);
    idle(4);

    // Gap of one independent instruction.
    alu(9, 11, 12, 0);
    alu(13, 14, 15, 0);
    repeat (3) alu(10, 9, 2, 0);
    idle(4);

    // XZR producer and reader never stall.
    ldur(31, 10);
    alu(3, 31, 31, 0);
    alu(31, 4, 4, 0);
    alu(3, 31, 31, 0);
    idle(4);

    // Stall in progress when a taken branch arrives, then a flushed producer.
    alu(1, 2, 3, 0);
    alu(2, 1, 3, 0);
    alu(2, 1, 3, 1);
    alu(2, 1, 3, 0);
    idle(4);
    ldur(12, 3);
    alu(4, 12, 12, 1);
    alu(4, 12, 12, 0);
    idle(4);

    // Two sources matching different entries: youngest decides.
    alu(20, 2, 3, 0);
    alu(21, 2, 3, 0);
    repeat (3) alu(22, 20, 21, 0);
    idle(4);

    // Saturation of the 2-bit counter over six stall cycles.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    alu(4, 2, 3, 0);
    repeat (4) alu(6, 4, 4, 0);
    alu(5, 2, 3, 0);
    repeat (4) alu(6, 5, 0, 0);
    check("cnt_saturate_2bit", 32'(cnt_c), 32'd3);
    check("cnt_two_deps_nofwd", 32'(cnt_a), 32'd4);
    idle(2);

    // Reset asserted mid-stall.
    alu(9, 2, 3, 0);
    alu(6, 9, 9, 0);
    cycle(1, 9, 1, 9, 1, 6, 1, 0, 0, 1);
    alu(6, 9, 9, 0);
    check("cnt_after_mid_stall_reset", 32'(cnt_a), 32'd0);
    idle(3);

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] r1, r2, rd;
      logic       rst;
      r1  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      r2  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      rd  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      rst = ($urandom_range(0, 49) == 0);
      cycle(($urandom_range(0, 4) != 0), r1, 1'($urandom), r2, 1'($urandom),
            rd, 1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0), rst);
    end
    idle(2);

    // Drain the scoreboard queue with a bounded wait.
    wait_cnt = 0;
    while ((exp_q.size() != 0) && (wait_cnt < 10)) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_scoreboard
